// File: rtl/serial_alu.sv
// Digit-serial ALU: processes WIDTH-bit operands DIGIT_W bits per cycle,
// least significant digit first, with a start/done handshake. Result and
// flags are only updated when the last digit has been processed.
module serial_alu #(
    parameter int WIDTH   = 32,
    parameter int DIGIT_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic [3:0]       sel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] f_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             zero_o
);

    localparam int N     = WIDTH / DIGIT_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    // One extra bit holds the shift fill so a right shift can read one bit
    // past the current digit; a left shift pre-loads cin below A instead.
    logic [WIDTH:0]       a_sh;
    logic [WIDTH-1:0]     b_sh;
    logic [WIDTH-1:0]     f_acc;
    logic [3:0]           sel_r;
    // Arithmetic carry chain; for shifts it parks the shifted-out bit.
    logic                 carry;

    logic [DIGIT_W-1:0]   a_dig;
    logic [DIGIT_W-1:0]   b_dig;
    logic [DIGIT_W-1:0]   bop;
    logic [DIGIT_W-1:0]   res_dig;
    logic [DIGIT_W:0]     sum;
    logic                 carry_nxt;
    logic                 ovf_dig;
    logic                 is_arith;
    logic                 last;
    logic [WIDTH+DIGIT_W-1:0] f_wide;

    // Per-digit datapath: operand B selection, digit adder, logic/shift
    // result and the accumulator with the new digit inserted at the top.
    always_comb begin
        a_dig    = a_sh[DIGIT_W-1:0];
        b_dig    = b_sh[DIGIT_W-1:0];
        is_arith = (sel_r[3:2] == 2'b00);
        last     = (cnt == CNT_W'(N - 1));

        case (sel_r[1:0])
            2'b00:   bop = '0;
            2'b01:   bop = b_dig;
            2'b10:   bop = ~b_dig;
            default: bop = '1;
        endcase

        sum       = {1'b0, a_dig} + {1'b0, bop} + {{DIGIT_W{1'b0}}, carry};
        carry_nxt = sum[DIGIT_W];
        // Same-sign operands giving a different-sign sum is equivalent to
        // carry-into-MSB differing from carry-out-of-MSB.
        ovf_dig   = (a_dig[DIGIT_W-1] ~^ bop[DIGIT_W-1]) &
                    (sum[DIGIT_W-1] ^ a_dig[DIGIT_W-1]);

        res_dig = '0;
        case (sel_r[3:2])
            2'b00: res_dig = sum[DIGIT_W-1:0];
            2'b01: begin
                case (sel_r[1:0])
                    2'b00:   res_dig = a_dig & b_dig;
                    2'b01:   res_dig = a_dig | b_dig;
                    2'b10:   res_dig = a_dig ^ b_dig;
                    default: res_dig = ~a_dig;
                endcase
            end
            2'b10:   res_dig = a_sh[DIGIT_W:1];
            default: res_dig = a_dig;
        endcase

        f_wide = {res_dig, f_acc};
    end

    // Control FSM and datapath registers: capture on start, one digit per
    // cycle while running, publish result and flags on the final digit.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            f_acc  <= '0;
            sel_r  <= '0;
            carry  <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            f_o    <= '0;
            cout_o <= 1'b0;
            ovf_o  <= 1'b0;
            zero_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_sh   <= (sel_i[3:2] == 2'b11) ? {a_i, cin_i} : {cin_i, a_i};
                        b_sh   <= b_i;
                        sel_r  <= sel_i;
                        cnt    <= '0;
                        f_acc  <= '0;
                        if (sel_i[3])
                            carry <= sel_i[2] ? a_i[WIDTH-1] : a_i[0];
                        else
                            carry <= sel_i[2] ? 1'b0 : cin_i;
                        busy_o <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT_W;
                    b_sh  <= b_sh >> DIGIT_W;
                    f_acc <= f_wide[WIDTH+DIGIT_W-1:DIGIT_W];
                    cnt   <= cnt + 1'b1;
                    if (is_arith)
                        carry <= carry_nxt;
                    if (last) begin
                        f_o    <= f_wide[WIDTH+DIGIT_W-1:DIGIT_W];
                        zero_o <= (f_wide[WIDTH+DIGIT_W-1:DIGIT_W] == '0);
                        cout_o <= is_arith ? carry_nxt : carry;
                        ovf_o  <= is_arith ? ovf_dig : 1'b0;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// Directed testbench for serial_alu: an 8-bit bit-serial instance for the
// functional and handshake scenarios and a 32-bit nibble-serial instance.
module tb_serial_alu;

    typedef struct {
        logic [3:0] s;
        logic [7:0] av;
        logic [7:0] bv;
        logic       c;
        logic [7:0] ef;
        logic       ec;
        logic       eo;
        logic       ez;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic [3:0]  sel;
    logic        busy;
    logic        done;
    logic [7:0]  f;
    logic        cout;
    logic        ovf;
    logic        zero;

    logic        w_start;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_cin;
    logic [3:0]  w_sel;
    logic        w_busy;
    logic        w_done;
    logic [31:0] w_f;
    logic        w_cout;
    logic        w_ovf;
    logic        w_zero;

    int checks;
    int failures;

    serial_alu #(.WIDTH(8), .DIGIT_W(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .a_i(a), .b_i(b),
        .cin_i(cin), .sel_i(sel), .busy_o(busy), .done_o(done), .f_o(f),
        .cout_o(cout), .ovf_o(ovf), .zero_o(zero)
    );

    serial_alu #(.WIDTH(32), .DIGIT_W(4)) dut_wide (
        .clk_i(clk), .rst_ni(rst_n), .start_i(w_start), .a_i(w_a), .b_i(w_b),
        .cin_i(w_cin), .sel_i(w_sel), .busy_o(w_busy), .done_o(w_done), .f_o(w_f),
        .cout_o(w_cout), .ovf_o(w_ovf), .zero_o(w_zero)
    );

    // Free-running clock shared by both instances.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one start cycle, then scramble the inputs so only the
    // captured copies can produce the right answer.
    task automatic start_op(input logic [3:0] s, input logic [7:0] av,
                            input logic [7:0] bv, input logic c);
        @(negedge clk);
        start = 1'b1;
        sel   = s;
        a     = av;
        b     = bv;
        cin   = c;
        @(negedge clk);
        start = 1'b0;
        sel   = 4'($urandom);
        a     = 8'($urandom);
        b     = 8'($urandom);
        cin   = 1'($urandom);
    endtask

    // Count negedges until done is seen, bounded at 20.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done !== 1'b1 && cyc < 20);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, f, cout, ovf, zero} !== 13'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", {busy, done, f, cout, ovf, zero});
        end
        checks++;
        if ({w_busy, w_done, w_f, w_cout, w_ovf, w_zero} !== 37'h0) begin
            failures++;
            $display("[TB] FAIL reset_wide_outputs: got %h expected 0",
                     {w_busy, w_done, w_f, w_cout, w_ovf, w_zero});
        end
        rst_n = 1'b1;
    endtask

    task automatic run_table(input vec_t v[], input string tag);
        int cyc;
        foreach (v[i]) begin
            start_op(v[i].s, v[i].av, v[i].bv, v[i].c);
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL %s_busy[%0d]: got %b expected 1", tag, i, busy);
            end
            wait_done(cyc);
            checks++;
            if (cyc !== 8) begin
                failures++;
                $display("[TB] FAIL %s_latency[%0d]: got %0d expected 8", tag, i, cyc);
            end
            checks++;
            if ({f, cout, ovf, zero} !== {v[i].ef, v[i].ec, v[i].eo, v[i].ez}) begin
                failures++;
                $display("[TB] FAIL %s_result[%0d]: got f=%h c=%b o=%b z=%b expected f=%h c=%b o=%b z=%b",
                         tag, i, f, cout, ovf, zero, v[i].ef, v[i].ec, v[i].eo, v[i].ez);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || f !== v[i].ef) begin
                failures++;
                $display("[TB] FAIL %s_pulse_hold[%0d]: got done=%b f=%h expected done=0 f=%h",
                         tag, i, done, f, v[i].ef);
            end
        end
    endtask

    task automatic test_arith();
        vec_t v[];
        v = new[4];
        v[0] = '{4'b0001, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        v[1] = '{4'b0010, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
        v[2] = '{4'b0011, 8'h00, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        v[3] = '{4'b0000, 8'hFF, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        run_table(v, "arith");
    endtask

    task automatic test_logic_shift();
        vec_t v[];
        v = new[7];
        v[0] = '{4'b0100, 8'hA5, 8'h0F, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0};
        v[1] = '{4'b0101, 8'hA5, 8'h0F, 1'b1, 8'hAF, 1'b0, 1'b0, 1'b0};
        v[2] = '{4'b0110, 8'hA5, 8'h0F, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0};
        v[3] = '{4'b0111, 8'hA5, 8'h0F, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
        v[4] = '{4'b1000, 8'hA5, 8'h00, 1'b1, 8'hD2, 1'b1, 1'b0, 1'b0};
        v[5] = '{4'b1100, 8'hA5, 8'h00, 1'b0, 8'h4A, 1'b1, 1'b0, 1'b0};
        v[6] = '{4'b1011, 8'h01, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        run_table(v, "logic_shift");
    endtask

    task automatic test_ignore_start();
        int n;
        int ndone;
        int first_at;
        logic [7:0] fdone;
        ndone    = 0;
        first_at = -1;
        fdone    = 8'h00;
        n        = 0;
        start_op(4'b0101, 8'h30, 8'h03, 1'b0);
        repeat (2) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        sel   = 4'b0001;
        a     = 8'h01;
        b     = 8'h01;
        cin   = 1'b0;
        repeat (15) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (first_at < 0) begin
                    first_at = n;
                    fdone    = f;
                end
            end
        end
        checks++;
        if (ndone !== 1 || first_at !== 8) begin
            failures++;
            $display("[TB] FAIL ignore_start_done: got count=%0d at=%0d expected count=1 at=8", ndone, first_at);
        end
        checks++;
        if (fdone !== 8'h33) begin
            failures++;
            $display("[TB] FAIL ignore_start_result: got %h expected 33", fdone);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_op(4'b0110, 8'hF0, 8'h3C, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc !== 8 || f !== 8'hCC) begin
            failures++;
            $display("[TB] FAIL b2b_first: got cyc=%0d f=%h expected cyc=8 f=cc", cyc, f);
        end
        start = 1'b1;
        sel   = 4'b0001;
        a     = 8'h12;
        b     = 8'h34;
        cin   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || f !== 8'hCC) begin
            failures++;
            $display("[TB] FAIL b2b_accept: got busy=%b f=%h expected busy=1 f=cc", busy, f);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 8 || {f, cout, ovf, zero} !== {8'h47, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL b2b_second: got cyc=%0d f=%h c=%b o=%b z=%b expected cyc=8 f=47 c=0 o=0 z=0",
                     cyc, f, cout, ovf, zero);
        end
    endtask

    task automatic test_mid_reset();
        int ndone;
        int cyc;
        start_op(4'b0001, 8'h0F, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, f, cout, ovf, zero} !== 13'h0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs: got %h expected 0", {busy, done, f, cout, ovf, zero});
        end
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++;
            $display("[TB] FAIL midreset_no_done: got %0d expected 0", ndone);
        end
        start_op(4'b0001, 8'h0F, 8'h01, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc !== 8 || f !== 8'h10) begin
            failures++;
            $display("[TB] FAIL midreset_restart: got cyc=%0d f=%h expected cyc=8 f=10", cyc, f);
        end
    endtask

    task automatic test_wide();
        int cyc;
        @(negedge clk);
        w_start = 1'b1;
        w_sel   = 4'b0001;
        w_a     = 32'h7FFF_FFFF;
        w_b     = 32'h0000_0001;
        w_cin   = 1'b0;
        @(negedge clk);
        w_start = 1'b0;
        w_a     = 32'h0;
        w_b     = 32'h0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (w_done !== 1'b1 && cyc < 20);
        checks++;
        if (cyc !== 8) begin
            failures++;
            $display("[TB] FAIL wide_latency: got %0d expected 8", cyc);
        end
        checks++;
        if ({w_f, w_cout, w_ovf, w_zero} !== {32'h8000_0000, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL wide_result: got f=%h c=%b o=%b z=%b expected f=80000000 c=0 o=1 z=0",
                     w_f, w_cout, w_ovf, w_zero);
        end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        cin      = 1'b0;
        sel      = 4'h0;
        w_start  = 1'b0;
        w_a      = 32'h0;
        w_b      = 32'h0;
        w_cin    = 1'b0;
        w_sel    = 4'h0;
        test_reset();
        test_arith();
        test_logic_shift();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
